// File: rtl/ahb_slave_mem_interface.sv
// AHB-Lite slave backed by a small register-file memory.
// Programmable wait states, two-cycle ERROR response, write-to-read forwarding.
module ahb_slave_mem_interface #(
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic [1:0]  hresp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_ERR1,
    S_ERR2
  } state_e;

  localparam int AW = (MEM_DEPTH > 2) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic          wr_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem_q [MEM_DEPTH];

  logic          accept;
  logic          bad;
  logic          commit;
  logic [AW-1:0] ld_idx;
  logic [31:0]   rdata_d;

  always_comb begin
    accept = hsel && htrans[1] &&
             (state_q == S_IDLE || state_q == S_XFER ||
              state_q == S_ERR2);
    bad    = (haddr[1:0] != 2'b00) ||
             (haddr[31:2] >= 30'(MEM_DEPTH));
    commit = (state_q == S_XFER) && wr_q;
    ld_idx = (state_q == S_WAIT) ? idx_q : haddr[AW+1:2];
    // A read landing on the word being committed this edge sees the new data
    rdata_d = (commit && ld_idx == idx_q) ? hwdata : mem_q[ld_idx];
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      if (commit) mem_q[idx_q] <= hwdata;
      case (state_q)
        S_IDLE, S_XFER, S_ERR2: begin
          if (accept) begin
            idx_q <= haddr[AW+1:2];
            wr_q  <= hwrite;
            if (bad) begin
              state_q <= S_ERR1;
            end else if (WAIT_CYCLES == 0) begin
              state_q <= S_XFER;
              if (!hwrite) rdata_q <= rdata_d;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WLOAD;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_XFER;
            if (!wr_q) rdata_q <= rdata_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ERR1:  state_q <= S_ERR2;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hrdata = rdata_q;
  assign hready = !(state_q == S_WAIT || state_q == S_ERR1);
  assign hresp  = (state_q == S_ERR1 || state_q == S_ERR2) ?
                  2'b01 : 2'b00;

endmodule

// File: tb/tb_ahb_slave_mem_interface.sv
// Directed vector bench: three instances with WAIT_CYCLES 0, 1 and 3.
// Each vector drives one cycle and checks the chosen instance after the edge.
module tb_ahb_slave_mem_interface;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] BSY = 2'b01;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ER  = 2'b01;

  typedef struct {
    int          dut;
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        rdy;
    logic [1:0]  resp;
    logic        chk_rd;
    logic [31:0] rd;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn [3];
  logic        sel [3];
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [31:0] rd [3];
  logic        rdy [3];
  logic [1:0]  resp [3];

  int pass_cnt = 0;
  int total    = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  ahb_slave_mem_interface #(.MEM_DEPTH(16), .WAIT_CYCLES(0)) u0 (
    .hclk(clk), .hresetn(rstn[0]), .hsel(sel[0]), .haddr(haddr),
    .hwrite(hwrite), .htrans(htrans), .hwdata(hwdata),
    .hrdata(rd[0]), .hready(rdy[0]), .hresp(resp[0]));

  ahb_slave_mem_interface #(.MEM_DEPTH(16), .WAIT_CYCLES(1)) u1 (
    .hclk(clk), .hresetn(rstn[1]), .hsel(sel[1]), .haddr(haddr),
    .hwrite(hwrite), .htrans(htrans), .hwdata(hwdata),
    .hrdata(rd[1]), .hready(rdy[1]), .hresp(resp[1]));

  ahb_slave_mem_interface #(.MEM_DEPTH(16), .WAIT_CYCLES(3)) u3 (
    .hclk(clk), .hresetn(rstn[2]), .hsel(sel[2]), .haddr(haddr),
    .hwrite(hwrite), .htrans(htrans), .hwdata(hwdata),
    .hrdata(rd[2]), .hready(rdy[2]), .hresp(resp[2]));

  function automatic vec_t mk(int d, logic s, logic [1:0] t,
                              logic [31:0] a, logic w, logic [31:0] wd,
                              logic ry, logic [1:0] rs, logic c,
                              logic [31:0] r, string n);
    vec_t v;
    v.dut = d; v.sel = s; v.trans = t; v.addr = a; v.wr = w;
    v.wdata = wd; v.rdy = ry; v.resp = rs; v.chk_rd = c;
    v.rd = r; v.name = n;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", n, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic run(vec_t v, logic r);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel[i]  = (i == v.dut) ? v.sel : 1'b0;
      rstn[i] = (i == v.dut) ? r : 1'b1;
    end
    htrans = v.trans;
    haddr  = v.addr;
    hwrite = v.wr;
    hwdata = v.wdata;
    @(posedge clk);
    #1;
    chk({v.name, ".hready"}, 32'(rdy[v.dut]), 32'(v.rdy));
    chk({v.name, ".hresp"}, 32'(resp[v.dut]), 32'(v.resp));
    if (v.chk_rd) chk({v.name, ".hrdata"}, rd[v.dut], v.rd);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0;
      sel[i]  = 1'b0;
    end
    htrans = IDL; haddr = '0; hwrite = 1'b0; hwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d.hready", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("rst%0d.hresp", i), 32'(resp[i]), 32'd0);
      chk($sformatf("rst%0d.hrdata", i), rd[i], 32'd0);
    end

    // WAIT_CYCLES=1 write then read back
    vq.push_back(mk(1,1,NSQ,32'h08,1,32'hDEADBEEF,0,OK,0,0,"a_wr_addr"));
    vq.push_back(mk(1,0,IDL,32'h00,0,32'hDEADBEEF,1,OK,0,0,"a_wr_xfer"));
    vq.push_back(mk(1,1,NSQ,32'h08,0,32'hDEADBEEF,0,OK,0,0,"a_rd_addr"));
    vq.push_back(mk(1,0,IDL,32'h00,0,32'h0,1,OK,1,32'hDEADBEEF,"a_rd_xfer"));
    vq.push_back(mk(1,0,IDL,32'h00,0,32'h0,1,OK,1,32'hDEADBEEF,"a_idle"));
    // WAIT_CYCLES=0 back-to-back with forwarding
    vq.push_back(mk(0,1,NSQ,32'h04,1,32'h0,1,OK,0,0,"b_wr"));
    vq.push_back(mk(0,1,NSQ,32'h04,0,32'h12345678,1,OK,1,32'h12345678,"b_rd_fwd"));
    vq.push_back(mk(0,0,IDL,32'h00,0,32'h0,1,OK,1,32'h12345678,"b_idle"));
    vq.push_back(mk(0,1,NSQ,32'h04,0,32'h0,1,OK,1,32'h12345678,"b_rd_mem"));
    // out-of-range write
    vq.push_back(mk(1,1,NSQ,32'h40,1,32'hFFFFFFFF,0,ER,1,32'hDEADBEEF,"c_err1"));
    vq.push_back(mk(1,0,IDL,32'h00,0,32'hFFFFFFFF,1,ER,1,32'hDEADBEEF,"c_err2"));
    vq.push_back(mk(1,0,IDL,32'h00,0,32'hFFFFFFFF,1,OK,1,32'hDEADBEEF,"c_idle"));
    vq.push_back(mk(1,1,NSQ,32'h00,0,32'h0,0,OK,0,0,"c_rd0_addr"));
    vq.push_back(mk(1,0,IDL,32'h00,0,32'h0,1,OK,1,32'h0,"c_rd0_xfer"));
    // misaligned read keeps previous hrdata; then pipelined accept in ERR2
    vq.push_back(mk(1,1,NSQ,32'h08,0,32'h0,0,OK,0,0,"d_rd8_addr"));
    vq.push_back(mk(1,0,IDL,32'h00,0,32'h0,1,OK,1,32'hDEADBEEF,"d_rd8_xfer"));
    vq.push_back(mk(1,1,NSQ,32'h06,0,32'h0,0,ER,1,32'hDEADBEEF,"d_mis1"));
    vq.push_back(mk(1,0,IDL,32'h00,0,32'h0,1,ER,1,32'hDEADBEEF,"d_mis2"));
    vq.push_back(mk(1,0,IDL,32'h00,0,32'h0,1,OK,1,32'hDEADBEEF,"d_idle"));
    vq.push_back(mk(1,1,NSQ,32'h06,0,32'h0,0,ER,0,0,"d_mis1b"));
    vq.push_back(mk(1,1,NSQ,32'h00,0,32'h0,1,ER,1,32'hDEADBEEF,"d_err1_ign"));
    vq.push_back(mk(1,1,NSQ,32'h08,0,32'h0,0,OK,0,0,"d_b2b"));
    vq.push_back(mk(1,0,IDL,32'h00,0,32'h0,1,OK,1,32'hDEADBEEF,"d_b2b_x"));
    // IDLE/BUSY/unselected are zero-wait and inert
    vq.push_back(mk(1,1,BSY,32'h08,1,32'h0,1,OK,1,32'hDEADBEEF,"e_busy"));
    vq.push_back(mk(1,1,IDL,32'h08,1,32'h0,1,OK,0,0,"e_idle"));
    vq.push_back(mk(1,0,NSQ,32'h08,1,32'h0,1,OK,0,0,"e_nosel"));
    vq.push_back(mk(1,0,IDL,32'h08,1,32'h0,1,OK,1,32'hDEADBEEF,"e_after"));
    vq.push_back(mk(1,1,NSQ,32'h08,0,32'h0,0,OK,0,0,"e_rd"));
    vq.push_back(mk(1,0,IDL,32'h00,0,32'h0,1,OK,1,32'hDEADBEEF,"e_rdx"));
    // WAIT_CYCLES=3 full write and read
    vq.push_back(mk(2,1,NSQ,32'h14,1,32'h0BADF00D,0,OK,0,0,"f_wr"));
    vq.push_back(mk(2,0,IDL,32'h00,0,32'h0BADF00D,0,OK,0,0,"f_w2"));
    vq.push_back(mk(2,0,IDL,32'h00,0,32'h0BADF00D,0,OK,0,0,"f_w3"));
    vq.push_back(mk(2,0,IDL,32'h00,0,32'h0BADF00D,1,OK,0,0,"f_wx"));
    vq.push_back(mk(2,0,IDL,32'h00,0,32'h0BADF00D,1,OK,0,0,"f_done"));
    vq.push_back(mk(2,1,NSQ,32'h14,0,32'h0,0,OK,0,0,"f_rd"));
    vq.push_back(mk(2,0,IDL,32'h00,0,32'h0,0,OK,0,0,"f_r2"));
    vq.push_back(mk(2,0,IDL,32'h00,0,32'h0,0,OK,0,0,"f_r3"));
    vq.push_back(mk(2,0,IDL,32'h00,0,32'h0,1,OK,1,32'h0BADF00D,"f_rx"));

    for (int i = 0; i < vq.size(); i++) run(vq[i], 1'b1);

    // reset during the 2nd wait cycle of a WAIT_CYCLES=3 write
    run(mk(2,1,NSQ,32'h0C,1,32'hA5A5A5A5,0,OK,0,0,"g_wr"), 1'b1);
    run(mk(2,0,IDL,32'h00,0,32'hA5A5A5A5,0,OK,0,0,"g_w2"), 1'b1);
    run(mk(2,1,NSQ,32'h0C,1,32'hA5A5A5A5,1,OK,1,32'h0,"g_rst"), 1'b0);
    run(mk(2,0,IDL,32'h00,0,32'hA5A5A5A5,1,OK,1,32'h0,"g_post"), 1'b1);
    run(mk(2,1,NSQ,32'h0C,0,32'h0,0,OK,0,0,"g_rd"), 1'b1);
    run(mk(2,0,IDL,32'h00,0,32'h0,0,OK,0,0,"g_r2"), 1'b1);
    run(mk(2,0,IDL,32'h00,0,32'h0,0,OK,0,0,"g_r3"), 1'b1);
    run(mk(2,0,IDL,32'h00,0,32'h0,1,OK,1,32'h0,"g_rx"), 1'b1);
    run(mk(2,1,NSQ,32'h14,0,32'h0,0,OK,0,0,"g_rd14"), 1'b1);
    run(mk(2,0,IDL,32'h00,0,32'h0,0,OK,0,0,"g_r14b"), 1'b1);
    run(mk(2,0,IDL,32'h00,0,32'h0,0,OK,0,0,"g_r14c"), 1'b1);
    run(mk(2,0,IDL,32'h00,0,32'h0,1,OK,1,32'h0,"g_r14x"), 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem_interface.md
AHB_SLAVE_MEM_INTERFACE -- requirements
Module: ahb_slave_mem_interface

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 16, meaning the number of 32-bit words in the internal memory (power of 2, 2..256).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning the number of wait cycles (hready=0) inserted before each OKAY data phase (0..15).
REQ-003 SHALL have port hclk, input, 1 bit: the single clock; all logic is clocked on the rising edge.
REQ-004 SHALL have port hresetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port hsel, input, 1 bit: slave select from the decoder.
REQ-006 SHALL have port haddr, input, 32 bits: transfer address.
REQ-007 SHALL have port hwrite, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port htrans, input, 2 bits: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-009 SHALL have port hwdata, input, 32 bits: write data, valid in the data phase.
REQ-010 SHALL have port hrdata, output, 32 bits: read data.
REQ-011 SHALL have port hready, output, 1 bit: 1 = transfer complete, 0 = extend the transfer.
REQ-012 SHALL have port hresp, output, 2 bits: 00 OKAY, 01 ERROR; 10 and 11 are never driven.

Function
REQ-013 SHALL accept a transfer at a rising edge only when hsel=1, htrans is NONSEQ or SEQ, and the state is S_IDLE, S_XFER or S_ERR2; the accepted haddr and hwrite are latched at that edge.
REQ-014 SHALL ignore IDLE and BUSY transfers, answering with hready=1 and hresp=OKAY (zero-wait).
REQ-015 SHALL flag the accepted transfer as an error when haddr[1:0]!=0 or the word index haddr[31:2] >= MEM_DEPTH.
REQ-016 SHALL implement states S_IDLE, S_WAIT, S_XFER, S_ERR1 and S_ERR2.
REQ-017 SHALL make hready and hresp decodes of the state only: S_IDLE 1/OKAY, S_WAIT 0/OKAY, S_XFER 1/OKAY, S_ERR1 0/ERROR, S_ERR2 1/ERROR.
REQ-018 SHALL transition on acceptance as follows: an error goes to S_ERR1; with WAIT_CYCLES=0 it goes to S_XFER; otherwise it goes to S_WAIT with a wait counter loaded to WAIT_CYCLES-1.
REQ-019 SHALL, in S_WAIT, decrement the counter each cycle and go to S_XFER when the counter is 0, giving exactly WAIT_CYCLES cycles with hready=0.
REQ-020 SHALL go from S_ERR1 to S_ERR2 unconditionally, producing a two-cycle ERROR response.
REQ-021 SHALL, from S_XFER or S_ERR2, go to the next accepted transfer's state if one is accepted (back-to-back pipelining); otherwise it goes to S_IDLE.
REQ-022 SHALL, in S_WAIT and S_ERR1, ignore hsel, htrans, haddr and hwrite.
REQ-023 SHALL, for a write, write hwdata into memory at the rising edge that ends the S_XFER cycle.
REQ-024 SHALL, for a read, load hrdata from memory at the edge entering S_XFER and hold it until the next read load; hrdata is unchanged by writes and errors.
REQ-025 SHALL forward hwdata to hrdata when a read enters S_XFER at the same edge that commits a write to the same word index.
REQ-026 SHALL never modify memory during an error transfer.

Reset
REQ-027 SHALL, when hresetn=0 at a rising edge, set state=S_IDLE, hready=1, hresp=OKAY, hrdata=0, the wait counter to 0 and all memory words to 0.
REQ-028 SHALL, when reset is applied mid-transfer (S_WAIT, S_XFER or S_ERR1), abandon the transfer with no memory write, and accept no transfer at the reset edge.

Verification
REQ-029 SHALL be verified by: reset, then a NONSEQ write of 0xDEADBEEF to 0x08 with WAIT_CYCLES=1 -> 1 cycle with hready=0, then hready=1/OKAY; a read of 0x08 returns 0xDEADBEEF.
REQ-030 SHALL be verified by: WAIT_CYCLES=0, a back-to-back write of 0x12345678 to 0x04 followed by a read of 0x04 -> hready stays 1 and hrdata=0x12345678 in the read data phase (forwarding).
REQ-031 SHALL be verified by: a write to 0x40 (out of range at depth 16) -> hready=0/ERROR then hready=1/ERROR; memory is unchanged and a read of 0x00 returns 0.
REQ-032 SHALL be verified by: a misaligned read of 0x06 -> two-cycle ERROR, with hrdata holding its previous value.
REQ-033 SHALL be verified by: WAIT_CYCLES=3, a write to 0x0C with hresetn=0 during the 2nd wait cycle -> next cycle hready=1/OKAY, and a read of 0x0C returns 0.
REQ-034 SHALL be verified by: hsel=1 with htrans=BUSY or IDLE, then hsel=0 with htrans=NONSEQ -> hready=1/OKAY throughout and no state change.
